// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable frame format and a
// first-word-fall-through receive FIFO with sticky error reporting.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_25mhz,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          break_det
);

  localparam int OS_RATE = BAUD * OVERSAMPLE;
  localparam int DIV_RAW = (CLK_HZ + OS_RATE / 2) / OS_RATE;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW     = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP, BRK} state_t;

  state_t               state;
  logic                 sync1, sync2, rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 start_edge;
  logic [OSW-1:0]       os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_ok;
  logic                 stop_bad;
  logic                 any_low;
  logic                 push_req;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop, wr;

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign start_edge = (state == IDLE) && !sync2 && rx_prev;
  assign tick       = (tick_cnt == TW'(DIV - 1));

  // Tick phase is realigned to every detected start edge.
  always_ff @(posedge clk_25mhz) begin
    if (!rst || start_edge) tick_cnt <= '0;
    else if (tick)          tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    par_ok = 1'b1;
    if (PARITY == 1)      par_ok = ^{shreg, par_bit};
    else if (PARITY == 2) par_ok = ~^{shreg, par_bit};
  end

  assign any_low = stop_bad | ~sync2;

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_bad   <= 1'b0;
      push_req   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      break_det <= 1'b0;
      if (clr_err) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      case (state)
        IDLE: if (start_edge) begin
          state  <= START;
          os_cnt <= '0;
        end
        START: if (tick) begin
          if (os_cnt == OSW'(OVERSAMPLE / 2 - 1)) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            state   <= sync2 ? IDLE : DATA;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        DATA: if (tick) begin
          if (os_cnt == OSW'(OVERSAMPLE - 1)) begin
            os_cnt  <= '0;
            shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              stop_cnt <= '0;
              stop_bad <= 1'b0;
              state    <= (PARITY != 0) ? PAR_BIT : STOP;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        PAR_BIT: if (tick) begin
          if (os_cnt == OSW'(OVERSAMPLE - 1)) begin
            os_cnt  <= '0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        STOP: if (tick) begin
          if (os_cnt == OSW'(OVERSAMPLE - 1)) begin
            os_cnt   <= '0;
            stop_cnt <= stop_cnt + 1'b1;
            stop_bad <= any_low;
            // Leave on the final stop sample so the next start edge is caught.
            if (stop_cnt == 2'(STOP_BITS - 1)) begin
              if (any_low && shreg == '0) begin
                break_det <= 1'b1;
                state     <= BRK;
              end else if (any_low) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end else begin
                if (!par_ok) parity_err <= 1'b1;
                else         push_req   <= 1'b1;
                state <= IDLE;
              end
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        BRK: if (sync2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign full = (fifo_count == CW'(FIFO_DEPTH));
  assign pop  = rd_en && (fifo_count != '0);
  assign wr   = push_req && (!full || pop);

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (clr_err) overflow <= 1'b0;
      if (push_req && full && !pop) overflow <= 1'b1;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (wr) mem[wr_ptr] <= shreg;
  end

  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E1 instance (depth 4, 16 clk/bit)
// checked against a frame-level queue model of the receiver.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b;
  logic [2:0] cnt_a, cnt_b;
  logic       ovf_a, ovf_b, fe_a, fe_b, pe_a, pe_b, brk_a, brk_b;

  uart_rx_fifo #(.CLK_HZ(25000000), .BAUD(1562500), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk_25mhz(clk), .rst(rst), .rx(rx_a), .rd_en(rd_en_a), .clr_err(clr_a),
    .rd_data(data_a), .rd_valid(val_a), .fifo_count(cnt_a), .overflow(ovf_a),
    .frame_err(fe_a), .parity_err(pe_a), .break_det(brk_a));

  uart_rx_fifo #(.CLK_HZ(25000000), .BAUD(1562500), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk_25mhz(clk), .rst(rst), .rx(rx_b), .rd_en(rd_en_b), .clr_err(clr_b),
    .rd_data(data_b), .rd_valid(val_b), .fifo_count(cnt_b), .overflow(ovf_b),
    .frame_err(fe_b), .parity_err(pe_b), .break_det(brk_b));

  int errors = 0;
  int checks = 0;
  int brk_seen_a = 0;
  int brk_seen_b = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  bit e_ovf[2];
  bit e_fe[2];
  bit e_pe[2];

  always @(negedge clk) begin
    if (brk_a) brk_seen_a++;
    if (brk_b) brk_seen_b++;
  end

  // Drives one frame; pop_at (8N1 only) raises rd_en during that bit-clock.
  task automatic send(input bit sel, input logic [7:0] d, input bit par_bad,
                      input bit stop_val, input int pop_at);
    logic [10:0] bits;
    int nb;
    bit popped;
    popped = 1'b0;
    nb = sel ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (sel) begin
      bits[9]  = (^d) ^ par_bad;
      bits[10] = stop_val;
    end else begin
      bits[9] = stop_val;
    end
    for (int i = 0; i < nb * 16; i++) begin
      @(negedge clk);
      if (sel) rx_b = bits[i / 16];
      else     rx_a = bits[i / 16];
      if (!sel) begin
        if (i == pop_at && q_a.size() > 0) begin
          checks++;
          if (data_a !== q_a[0]) begin
            errors++;
            $display("FAIL pop_head: got %h expected %h", data_a, q_a[0]);
          end
          popped = 1'b1;
        end
        rd_en_a = (i == pop_at);
      end
    end
    @(negedge clk);
    rx_a = 1'b1;
    rx_b = 1'b1;
    rd_en_a = 1'b0;
    repeat (6) @(negedge clk);
    if (popped) void'(q_a.pop_front());
    if (!stop_val) begin
      if (d != 8'h00) e_fe[sel] = 1'b1;
    end else if (sel && par_bad) begin
      e_pe[sel] = 1'b1;
    end else if (sel) begin
      if (q_b.size() < 4) q_b.push_back(d);
      else e_ovf[1] = 1'b1;
    end else begin
      if (q_a.size() < 4) q_a.push_back(d);
      else e_ovf[0] = 1'b1;
    end
  endtask

  task automatic pop(input bit sel);
    @(negedge clk);
    if (sel) rd_en_b = 1'b1; else rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    if (sel && q_b.size() > 0) void'(q_b.pop_front());
    if (!sel && q_a.size() > 0) void'(q_a.pop_front());
  endtask

  task automatic clr(input bit sel);
    @(negedge clk);
    if (sel) clr_b = 1'b1; else clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    e_ovf[sel] = 1'b0;
    e_fe[sel]  = 1'b0;
    e_pe[sel]  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({val_a, cnt_a, data_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_fifo_a: got v=%b c=%0d d=%h expected 0 0 00", val_a, cnt_a, data_a);
    end
    checks++;
    if ({val_b, cnt_b, data_b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_fifo_b: got v=%b c=%0d d=%h expected 0 0 00", val_b, cnt_b, data_b);
    end
    checks++;
    if ({ovf_a, fe_a, pe_a, brk_a, ovf_b, fe_b, pe_b, brk_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {ovf_a, fe_a, pe_a, brk_a, ovf_b, fe_b, pe_b, brk_b});
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    send(0, 8'hA5, 0, 1, -1);
    checks++;
    if (data_a !== 8'hA5 || val_a !== 1'b1 || cnt_a !== 3'd1) begin
      errors++;
      $display("FAIL basic_rx: got d=%h v=%b c=%0d expected a5 1 1", data_a, val_a, cnt_a);
    end
    checks++;
    if ({ovf_a, fe_a, pe_a} !== 3'b000) begin
      errors++;
      $display("FAIL basic_flags: got %b expected 000", {ovf_a, fe_a, pe_a});
    end
    pop(0);
    checks++;
    if (val_a !== 1'b0 || cnt_a !== 3'd0 || data_a !== 8'h00) begin
      errors++;
      $display("FAIL basic_pop: got v=%b c=%0d d=%h expected 0 0 00", val_a, cnt_a, data_a);
    end
  endtask

  task automatic test_parity;
    send(1, 8'h03, 0, 1, -1);
    checks++;
    if (cnt_b !== 3'(q_b.size()) || data_b !== q_b[0] || pe_b !== e_pe[1]) begin
      errors++;
      $display("FAIL parity_good: got c=%0d d=%h pe=%b expected %0d %h %b",
               cnt_b, data_b, pe_b, q_b.size(), q_b[0], e_pe[1]);
    end
    send(1, 8'h03, 1, 1, -1);
    checks++;
    if (pe_b !== 1'b1 || pe_b !== e_pe[1] || cnt_b !== 3'(q_b.size())) begin
      errors++;
      $display("FAIL parity_bad: got pe=%b c=%0d expected 1 %0d", pe_b, cnt_b, q_b.size());
    end
    clr(1);
    checks++;
    if (pe_b !== 1'b0) begin
      errors++;
      $display("FAIL parity_clr: got %b expected 0", pe_b);
    end
    while (q_b.size() > 0) pop(1);
  endtask

  task automatic test_glitch;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (cnt_a !== 3'd0 || val_a !== 1'b0 || {ovf_a, fe_a, pe_a, brk_seen_a != 0} !== 4'b0000) begin
      errors++;
      $display("FAIL glitch: got c=%0d v=%b flags=%b expected 0 0 000",
               cnt_a, val_a, {ovf_a, fe_a, pe_a});
    end
    send(0, 8'h3C, 0, 1, -1);
    checks++;
    if (data_a !== q_a[0] || cnt_a !== 3'(q_a.size())) begin
      errors++;
      $display("FAIL glitch_next: got d=%h c=%0d expected %h %0d", data_a, cnt_a, q_a[0], q_a.size());
    end
    pop(0);
  endtask

  task automatic test_frame_break;
    int b0;
    send(0, 8'h55, 0, 0, -1);
    checks++;
    if (fe_a !== 1'b1 || fe_a !== e_fe[0] || cnt_a !== 3'd0) begin
      errors++;
      $display("FAIL frame_err: got fe=%b c=%0d expected 1 0", fe_a, cnt_a);
    end
    clr(0);
    b0 = brk_seen_a;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (320) @(negedge clk);
    checks++;
    if (brk_seen_a - b0 !== 1 || cnt_a !== 3'd0 || fe_a !== 1'b0) begin
      errors++;
      $display("FAIL break: got pulses=%0d c=%0d fe=%b expected 1 0 0", brk_seen_a - b0, cnt_a, fe_a);
    end
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 8'h41, 0, 1, -1);
    checks++;
    if (data_a !== 8'h41 || cnt_a !== 3'd1 || brk_seen_a - b0 !== 1) begin
      errors++;
      $display("FAIL after_break: got d=%h c=%0d pulses=%0d expected 41 1 1", data_a, cnt_a, brk_seen_a - b0);
    end
    pop(0);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) send(0, 8'h10 + 8'(i), 0, 1, -1);
    checks++;
    if (cnt_a !== 3'd4 || ovf_a !== 1'b1 || ovf_a !== e_ovf[0]) begin
      errors++;
      $display("FAIL overflow: got c=%0d ovf=%b expected 4 1", cnt_a, ovf_a);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_a !== q_a[0]) begin
        errors++;
        $display("FAIL ovf_content%0d: got %h expected %h", i, data_a, q_a[0]);
      end
      pop(0);
    end
    clr(0);
    for (int i = 0; i < 4; i++) send(0, 8'h20 + 8'(i), 0, 1, -1);
    // Push of the fifth frame lands on the clock edge after bit-clock 155.
    send(0, 8'h24, 0, 1, 155);
    checks++;
    if (cnt_a !== 3'd4 || ovf_a !== 1'b0 || ovf_a !== e_ovf[0]) begin
      errors++;
      $display("FAIL push_pop_full: got c=%0d ovf=%b expected 4 0", cnt_a, ovf_a);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_a !== q_a[0]) begin
        errors++;
        $display("FAIL pp_content%0d: got %h expected %h", i, data_a, q_a[0]);
      end
      pop(0);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    send(0, 8'h61, 0, 1, -1);
    send(0, 8'h62, 0, 1, -1);
    send(0, 8'h00, 0, 0, -1);
    bits = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rx_a = bits[i / 16];
    end
    @(negedge clk);
    rst = 1'b0;
    rx_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({val_a, cnt_a, data_a} !== 12'h000 || {ovf_a, fe_a, pe_a, brk_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid: got v=%b c=%0d d=%h flags=%b expected 0 0 00 0000",
               val_a, cnt_a, data_a, {ovf_a, fe_a, pe_a, brk_a});
    end
    rst = 1'b1;
    q_a.delete();
    e_ovf[0] = 1'b0;
    e_fe[0]  = 1'b0;
    e_pe[0]  = 1'b0;
    repeat (40) @(negedge clk);
    send(0, 8'h7E, 0, 1, -1);
    checks++;
    if (data_a !== 8'h7E || cnt_a !== 3'd1 || fe_a !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got d=%h c=%0d fe=%b expected 7e 1 0", data_a, cnt_a, fe_a);
    end
    pop(0);
  endtask

  task automatic test_random;
    logic [7:0] d;
    bit bad;
    for (int n = 0; n < 12; n++) begin
      if (q_a.size() > 0 && $urandom_range(0, 2) == 0) begin
        checks++;
        if (data_a !== q_a[0]) begin
          errors++;
          $display("FAIL rand_head_a: got %h expected %h", data_a, q_a[0]);
        end
        pop(0);
      end
      d = 8'($urandom);
      send(0, d, 0, 1, -1);
      checks++;
      if (cnt_a !== 3'(q_a.size()) || ovf_a !== e_ovf[0] || (q_a.size() > 0 && data_a !== q_a[0])) begin
        errors++;
        $display("FAIL rand_a%0d: got c=%0d ovf=%b d=%h expected %0d %b", n, cnt_a, ovf_a, data_a,
                 q_a.size(), e_ovf[0]);
      end
    end
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      bad = ($urandom_range(0, 2) == 0);
      send(1, d, bad, 1, -1);
      checks++;
      if (cnt_b !== 3'(q_b.size()) || pe_b !== e_pe[1] || ovf_b !== e_ovf[1]) begin
        errors++;
        $display("FAIL rand_b%0d: got c=%0d pe=%b ovf=%b expected %0d %b %b", n, cnt_b, pe_b, ovf_b,
                 q_b.size(), e_pe[1], e_ovf[1]);
      end
      if (q_b.size() > 2) begin
        checks++;
        if (data_b !== q_b[0]) begin
          errors++;
          $display("FAIL rand_head_b: got %h expected %h", data_b, q_b[0]);
        end
        pop(1);
      end
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_frame_break();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
